fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the LEGv8 pipeline; supplies the 32-bit word whose [31:21] feeds control's opcode_bits.
//  Owns the PC, issues one-outstanding valid/ready requests to instruction memory, registers the result in IF/ID.
//  Closes the branch loop: consumes branch/uncondbranch from control (resolved downstream with ALU zero) to redirect the PC.
// PARAMETERS
//  PC_W        64              PC / address width
//  INSTR_W     32              instruction width
//  PC_RESET    64'h0           PC value after reset
// PORTS
//  clk            in   1       single clock, rising edge
//  reset          in   1       synchronous, active-high
//  stall          in   1       hazard hold: IF/ID must not change
//  branch         in   1       conditional branch (CBZ) resolved this cycle
//  uncondbranch   in   1       unconditional branch (B) resolved this cycle
//  alu_zero       in   1       ALU zero flag paired with branch
//  branch_target  in   PC_W    redirect address
//  imem_req_valid out  1       fetch request valid
//  imem_req_ready in   1       memory accepts request
//  imem_addr      out  PC_W    request address (= pc)
//  imem_rsp_valid in   1       response word valid
//  imem_rsp_data  in   INSTR_W response word
//  if_id_valid    out  1       IF/ID holds a live instruction
//  if_id_pc       out  PC_W    PC of IF/ID instruction
//  if_id_instr    out  INSTR_W IF/ID instruction
// BEHAVIOUR
//  Reset (sync, high): pc<=PC_RESET, state<=S_REQ, if_id_valid<=0, if_id_pc<=0, if_id_instr<=0, hold buffer cleared.
//  Reset mid-operation aborts any outstanding request; responses arriving in S_REQ are ignored.
//  redirect = uncondbranch | (branch & alu_zero); target used as {branch_target[PC_W-1:2],2'b00}.
//  States: S_REQ (imem_req_valid=1), S_WAIT (awaiting rsp), S_HOLD (rsp captured, stalled), S_DROP (discard stale rsp).
//  S_REQ : req_valid=1, addr=pc; ready -> S_WAIT; else stay. imem_req_valid is 0 in all other states.
//  S_WAIT: rsp & !stall -> IF/ID<={1,pc,data}, pc<=pc+4, S_REQ.
//          rsp & stall  -> buffer<=data, S_HOLD (IF/ID unchanged).
//  S_HOLD: !stall -> IF/ID<={1,pc,buffer}, pc<=pc+4, S_REQ.
//  S_DROP: rsp -> discard, S_REQ; else stay. Only one request outstanding ever.
//  Bubble: when stall=0 and no instruction loaded this cycle, if_id_valid<=0.
//  Stall: if_id_* hold all values; pc does not advance.
//  Redirect (highest priority, overrides stall): pc<=target, if_id_valid<=0, buffer discarded, and
//    S_REQ+ready -> S_DROP; S_REQ+!ready -> S_REQ; S_WAIT+rsp -> S_REQ (rsp discarded);
//    S_WAIT+!rsp -> S_DROP; S_HOLD -> S_REQ; S_DROP+rsp -> S_REQ; S_DROP+!rsp -> S_DROP.
//  PC arithmetic: pc+4 modulo 2^PC_W (wraps at all-ones to 0, no flag).
//  Latency: request accept to IF/ID valid = memory latency +1 cycle; peak rate 1 instr / 2 cycles with 1-cycle memory.
//  imem_addr stable while imem_req_valid=1 and !ready (unless redirect/reset).
// STRUCTURE
//  definitions.vh: PC_RESET, INSTR_W, fetch state encodings (S_REQ/S_WAIT/S_HOLD/S_DROP), PC_INCR=4.
//  One sub-module: fetch_if_id_reg (IF/ID register with load/stall/flush, flush dominant).
//  FSM, PC register and next-PC mux stay in fetch_unit.
// TESTING
//  Reset then release, mem 1-cycle, words A,B,C at 0,4,8 -> if_id_pc 0,4,8 with instr A,B,C, if_id_valid pulses.
//  stall=1 for 3 cycles while rsp for 0x4 arrives -> IF/ID holds 0x0; on release IF/ID={1,0x4,B} one cycle later.
//  In S_WAIT for 0x8, uncondbranch=1 target 0x100 -> stale rsp dropped, if_id_valid=0, next IF/ID pc=0x100.
//  branch=1 alu_zero=0 -> no redirect, sequence continues 0xC; branch=1 alu_zero=1 target 0x102 -> fetch 0x100.
//  Redirect while stall=1 -> if_id_valid=0 next cycle regardless of stall.
//  reset asserted in S_WAIT, late rsp_valid arrives after release -> ignored; first IF/ID pc=PC_RESET.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the LEGv8 fetch stage: default widths, reset PC,
// PC increment and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int DEF_PC_W = 64;
  localparam int DEF_INSTR_W = 32;
  localparam logic [63:0] DEF_PC_RESET = 64'h0;
  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// Request: a transfer happens on a rising edge where imem_req_valid and imem_req_ready are both high;
// the master holds imem_addr stable while valid is high and ready is low. Response: imem_rsp_valid
// qualifies imem_rsp_data for one cycle, has no back-pressure and answers the single outstanding request.
interface fetch_unit_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: flush clears valid and dominates, load captures a new
// instruction, stall holds everything, otherwise a bubble is inserted.
module fetch_if_id_reg #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic               stall,
  input  logic [PC_W-1:0]    ld_pc,
  input  logic [INSTR_W-1:0] ld_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= ld_pc;
      instr <= ld_instr;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: owns the PC, keeps one request outstanding to instruction
// memory, and loads IF/ID; a resolved branch redirects the PC and flushes IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] PC_RESET = DEF_PC_RESET[PC_W-1:0]
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch,
  input  logic               uncondbranch,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    branch_target,
  fetch_unit_if.master       imem,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output fetch_state_e       dbg_state
);

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic               redirect;
  logic               load;
  logic               capture;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_nxt;
  logic [PC_W-1:0]    target;
  logic [INSTR_W-1:0] hold_buf;
  logic [INSTR_W-1:0] load_instr;

  assign redirect  = uncondbranch | (branch & alu_zero);
  assign target    = {branch_target[PC_W-1:2], 2'b00};
  assign imem.imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  // A redirect never loads; any response still owed to the old path goes through S_DROP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem.imem_req_ready) state_nxt = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem.imem_rsp_valid) state_nxt = (stall && !redirect) ? S_HOLD : S_REQ;
        else if (redirect)       state_nxt = S_DROP;
      end
      S_HOLD: if (redirect || !stall) state_nxt = S_REQ;
      S_DROP: if (imem.imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    load_instr = imem.imem_rsp_data;
    case (state)
      S_REQ:  imem.imem_req_valid = 1'b1;
      S_WAIT: begin
        if (imem.imem_rsp_valid && !redirect) begin
          capture = stall;
          load    = !stall;
        end
      end
      S_HOLD: begin
        load_instr = hold_buf;
        load       = !redirect && !stall;
      end
      default: ;
    endcase
  end

  // pc stays at the in-flight address until its word is loaded, so it doubles as the IF/ID pc.
  always_comb begin
    pc_nxt = pc;
    if (redirect)  pc_nxt = target;
    else if (load) pc_nxt = pc + PC_W'(PC_INCR);
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= PC_RESET;
    else       pc <= pc_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || redirect) hold_buf <= '0;
    else if (capture)      hold_buf <= imem.imem_rsp_data;
  end

  fetch_if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .load     (load),
    .stall    (stall),
    .ld_pc    (pc),
    .ld_instr (load_instr),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory with random latency/ready,
// random stall/branch/reset traffic, and a program-order scoreboard of expected IF/ID pcs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        uncondbranch;
  logic        alu_zero;
  logic [63:0] branch_target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  fetch_state_e dbg_state;

  fetch_unit_if #(.PC_W(64), .INSTR_W(32)) imem_bus ();

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .uncondbranch  (uncondbranch),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          edge_cnt = 0;
  int          last_load_edge = 0;
  int          loads = 0;
  logic [63:0] last_pc = '0;
  bit          have_last = 0;
  bit          directed = 1;

  // ---------------- memory model state ----------------
  bit          pending = 0;
  bit          delivering = 0;
  bit          stale = 0;
  int          delay = 0;
  int          lat_max = 1;
  logic [63:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program order restarts at a new PC on reset or redirect.
  task automatic fill_q(input logic [63:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  task automatic top_up();
    while (exp_q.size() > 0 && exp_q.size() < 16) exp_q.push_back(exp_q[$] + 64'd4);
  endtask

  // One memory step per negedge; inputs for the next rising edge are decided here.
  task automatic mem_step();
    if (delivering) begin
      delivering = 0;
      pending    = 0;
      stale      = 0;
    end
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = $urandom;
    if (pending) begin
      check("one_outstanding", 64'(imem_bus.imem_req_valid && !stale), 64'd0);
      imem_bus.imem_req_ready = 1'b0;
      delay--;
      if (delay <= 0) begin
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = mem_word(pend_addr);
        delivering = 1;
      end
    end else begin
      imem_bus.imem_req_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (reset) imem_bus.imem_req_ready = 1'b0;
      if (imem_bus.imem_req_ready && imem_bus.imem_req_valid) begin
        pending   = 1;
        pend_addr = imem_bus.imem_addr;
        delay     = directed ? 1 : $urandom_range(1, lat_max);
      end
    end
  endtask

  function automatic logic [63:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      1:       return 64'($urandom_range(0, 255));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- driver ----------------
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    branch = 1'b0;
    uncondbranch = 1'b0;
    alu_zero = 1'b0;
    branch_target = '0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
    fill_q(DEF_PC_RESET);
    repeat (3) @(negedge clk);

    // Back-to-back fetch with a 1-cycle memory and no hazards.
    for (int c = 0; c < 40; c++) begin
      reset = 1'b0;
      mem_step();
      top_up();
      @(negedge clk);
    end

    directed = 0;
    lat_max  = 4;
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch        = ($urandom_range(0, 15) == 0);
      uncondbranch  = ($urandom_range(0, 31) == 0);
      alu_zero      = $urandom_range(0, 1);
      branch_target = pick_target();
      if (reset) begin
        if (pending) stale = 1;
        fill_q(DEF_PC_RESET);
      end else if (uncondbranch || (branch && alu_zero)) begin
        fill_q(branch_target & ~64'd3);
      end
      mem_step();
      top_up();
      @(negedge clk);
    end

    reset = 1'b0;
    stall = 1'b0;
    branch = 1'b0;
    uncondbranch = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mem_step();
      top_up();
      @(negedge clk);
    end

    check("progress", 64'(loads >= 200), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- monitor ----------------
  initial begin
    logic [63:0] exp_pc;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (reset) begin
        check("reset_valid", 64'(if_id_valid), 64'd0);
        check("reset_pc", if_id_pc, 64'd0);
        check("reset_instr", 64'(if_id_instr), 64'd0);
        check("reset_req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
        check("reset_addr", imem_bus.imem_addr, DEF_PC_RESET);
        check("reset_state", 64'(dbg_state), 64'(S_REQ));
        last_load_edge = edge_cnt;
        have_last = 0;
      end else if (uncondbranch || (branch && alu_zero)) begin
        check("redirect_flush", 64'(if_id_valid), 64'd0);
        check("redirect_addr", imem_bus.imem_addr, branch_target & ~64'd3);
        have_last = 0;
      end else if (!stall) begin
        if (if_id_valid) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'(exp_q.size()));
          end else begin
            exp_pc = exp_q.pop_front();
            check("if_id_pc", if_id_pc, exp_pc);
            check("if_id_instr", 64'(if_id_instr), 64'(mem_word(exp_pc)));
            last_pc   = exp_pc;
            have_last = 1;
          end
          loads++;
          if (directed) check("load_gap", 64'(edge_cnt - last_load_edge), 64'd2);
          last_load_edge = edge_cnt;
        end else begin
          have_last = 0;
        end
      end else begin
        check("stall_hold_valid", 64'(if_id_valid), 64'(have_last));
        if (if_id_valid && have_last) begin
          check("stall_hold_pc", if_id_pc, last_pc);
          check("stall_hold_instr", 64'(if_id_instr), 64'(mem_word(last_pc)));
        end
      end
    end
  end

endmodule
